// File: rtl/bus_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM states, master id and op kind.
package bus_pkg;

  localparam int unsigned BUS_AW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } state_e;

  typedef logic mid_t;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the two masters.
// Round-robin on contention when BUS_ARBITER_ROUND_ROBIN_EN is defined, else fixed m0 priority.
module arb_pick
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last,
  output mid_t       grant
);

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    if (&req) begin
      grant = mid_t'(~last);
    end else begin
      grant = mid_t'(~req[0]);
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = mid_t'(~req[0]);
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave memory bus arbiter with a read timeout for unmapped addresses.
// Optional macro BUS_ARBITER_ROUND_ROBIN_EN switches arbitration to round-robin.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned AW      = BUS_AW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_ren,
  input  logic          m0_wen,
  input  logic [W-1:0]  m0_wdata,
  input  logic [3:0]    m0_wmask,
  output logic [W-1:0]  m0_rdata,
  output logic          m0_rd_valid,
  output logic          m0_wr_done,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_ren,
  input  logic          m1_wen,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m1_wmask,
  output logic [W-1:0]  m1_rdata,
  output logic          m1_rd_valid,
  output logic          m1_wr_done,
  output logic [AW-1:0] s_addr,
  output logic          s_ren,
  output logic          s_wen,
  output logic [W-1:0]  s_wdata,
  output logic [3:0]    s_wmask,
  input  logic [W-1:0]  s_rdata,
  input  logic          s_rd_valid,
  output logic          timeout
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state_q, state_d;
  mid_t          owner_q, owner_d;
  mid_t          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] req;
  mid_t       grant;
  op_e        win_op;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         wr_done;

  assign req = {m1_ren | m1_wen, m0_ren | m0_wen};

  arb_pick u_arb_pick (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  // A master raising both ren and wen is treated as a write.
  assign win_op = (grant ? m1_wen : m0_wen) ? OpWrite : OpRead;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    s_addr   = '0;
    s_ren    = 1'b0;
    s_wen    = 1'b0;
    s_wdata  = '0;
    s_wmask  = '0;
    rd_data  = '0;
    rd_valid = 1'b0;
    wr_done  = 1'b0;
    timeout  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = grant;
          last_d  = grant;
          addr_d  = grant ? m1_addr : m0_addr;
          wdata_d = grant ? m1_wdata : m0_wdata;
          wmask_d = grant ? m1_wmask : m0_wmask;
          cnt_d   = '0;
          state_d = (win_op == OpWrite) ? StWrite : StRead;
        end
      end
      StWrite: begin
        s_wen   = 1'b1;
        s_addr  = addr_q;
        s_wdata = wdata_q;
        s_wmask = wmask_q;
        wr_done = 1'b1;
        state_d = StIdle;
      end
      StRead: begin
        s_ren   = 1'b1;
        s_addr  = addr_q;
        rd_data = s_rdata;
        // Real data beats a timeout landing in the same cycle.
        if (s_rd_valid) begin
          rd_valid = 1'b1;
          state_d  = StIdle;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          rd_valid = 1'b1;
          rd_data  = '0;
          timeout  = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    m0_rdata    = (owner_q == 1'b0) ? rd_data : '0;
    m1_rdata    = (owner_q == 1'b1) ? rd_data : '0;
    m0_rd_valid = rd_valid & (owner_q == 1'b0);
    m1_rd_valid = rd_valid & (owner_q == 1'b1);
    m0_wr_done  = wr_done & (owner_q == 1'b0);
    m1_wr_done  = wr_done & (owner_q == 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table for single-master traffic plus
// hand-written sequences for contention, timeout, reset abort and starvation.
module tb_bus_arbiter;

  typedef struct packed {
    logic        m0_ren;
    logic        m0_wen;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wmask;
    logic        m1_ren;
    logic [15:0] m1_addr;
    logic [31:0] s_rdata;
    logic        s_rd_valid;
  } in_t;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        m0_rv;
    logic        m0_wd;
    logic [31:0] m0_rdata;
    logic        m1_rv;
    logic        m1_wd;
    logic [31:0] m1_rdata;
    logic        to;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk, rst_n;
  logic [15:0] m0_addr, m1_addr, s_addr;
  logic        m0_ren, m0_wen, m1_ren, m1_wen;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]  m0_wmask, m1_wmask, s_wmask;
  logic        m0_rd_valid, m1_rd_valid, m0_wr_done, m1_wr_done;
  logic        s_ren, s_wen, s_rd_valid, timeout;

  exp_t act;
  int   checks = 0;
  int   errors = 0;
  int   exp_last = 1;
  vec_t vecs[11];

  assign act = {s_ren, s_wen, s_addr, s_wdata, s_wmask, m0_rd_valid, m0_wr_done, m0_rdata,
                m1_rd_valid, m1_wr_done, m1_rdata, timeout};

  bus_arbiter #(.W(32), .AW(16), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_addr     (m0_addr),
    .m0_ren      (m0_ren),
    .m0_wen      (m0_wen),
    .m0_wdata    (m0_wdata),
    .m0_wmask    (m0_wmask),
    .m0_rdata    (m0_rdata),
    .m0_rd_valid (m0_rd_valid),
    .m0_wr_done  (m0_wr_done),
    .m1_addr     (m1_addr),
    .m1_ren      (m1_ren),
    .m1_wen      (m1_wen),
    .m1_wdata    (m1_wdata),
    .m1_wmask    (m1_wmask),
    .m1_rdata    (m1_rdata),
    .m1_rd_valid (m1_rd_valid),
    .m1_wr_done  (m1_wr_done),
    .s_addr      (s_addr),
    .s_ren       (s_ren),
    .s_wen       (s_wen),
    .s_wdata     (s_wdata),
    .s_wmask     (s_wmask),
    .s_rdata     (s_rdata),
    .s_rd_valid  (s_rd_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t rd_e(input int o, input logic [15:0] a, input logic [31:0] d,
                                input logic v, input logic to);
    exp_t e;
    e      = '0;
    e.ren  = 1'b1;
    e.addr = a;
    if (o == 0) begin
      e.m0_rdata = d;
      e.m0_rv    = v;
    end else begin
      e.m1_rdata = d;
      e.m1_rv    = v;
    end
    e.to = to;
    return e;
  endfunction

  function automatic exp_t wr_e(input int o, input logic [15:0] a, input logic [31:0] d,
                                input logic [3:0] m);
    exp_t e;
    e       = '0;
    e.wen   = 1'b1;
    e.addr  = a;
    e.wdata = d;
    e.wmask = m;
    if (o == 0) e.m0_wd = 1'b1;
    else        e.m1_wd = 1'b1;
    return e;
  endfunction

  // Expected winner when both masters request.
  function automatic int pick(input int last);
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    return 1 - last;
`else
    return 0 * last;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input in_t i);
    m0_ren     = i.m0_ren;
    m0_wen     = i.m0_wen;
    m0_addr    = i.m0_addr;
    m0_wdata   = i.m0_wdata;
    m0_wmask   = i.m0_wmask;
    m1_ren     = i.m1_ren;
    m1_wen     = 1'b0;
    m1_addr    = i.m1_addr;
    m1_wdata   = '0;
    m1_wmask   = '0;
    s_rdata    = i.s_rdata;
    s_rd_valid = i.s_rd_valid;
  endtask

  task automatic check(input string name, input exp_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, e);
    end
  endtask

  task automatic drop_ren(input int who);
    if (who == 0) m0_ren = 1'b0;
    else          m1_ren = 1'b0;
  endtask

  initial begin
    int f, s, w;
    vecs[0]  = '{'{1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h8004, 32'h0, 1'b0}, '0};
    vecs[1]  = '{'{1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h8004, 32'hAAAA5555, 1'b0},
                 rd_e(1, 16'h8004, 32'hAAAA5555, 1'b0, 1'b0)};
    vecs[2]  = '{'{1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h8004, 32'h0, 1'b0},
                 rd_e(1, 16'h8004, 32'h0, 1'b0, 1'b0)};
    vecs[3]  = '{'{1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h8004, 32'h12345678, 1'b1},
                 rd_e(1, 16'h8004, 32'h12345678, 1'b1, 1'b0)};
    vecs[4]  = '{'{1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h12345678, 1'b0}, '0};
    vecs[5]  = '{'{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 32'h0, 1'b0}, '0};
    vecs[6]  = '{'{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 32'h0, 1'b0},
                 wr_e(0, 16'h0010, 32'hDEADBEEF, 4'hF)};
    vecs[7]  = '{'{1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 1'b0}, '0};
    vecs[8]  = '{'{1'b1, 1'b1, 16'h0020, 32'h01020304, 4'h3, 1'b0, 16'h0, 32'h0, 1'b0}, '0};
    vecs[9]  = '{'{1'b1, 1'b1, 16'h0020, 32'h01020304, 4'h3, 1'b0, 16'h0, 32'h0, 1'b0},
                 wr_e(0, 16'h0020, 32'h01020304, 4'h3)};
    vecs[10] = '{'{1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 1'b0}, '0};

    // Reset held with busy inputs: everything must stay quiet.
    rst_n = 1'b0;
    apply('0);
    m0_ren     = 1'b1;
    m0_addr    = 16'h1234;
    m1_wen     = 1'b1;
    s_rd_valid = 1'b1;
    s_rdata    = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", '0);
    apply('0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step();
      apply(vecs[i].i);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].e);
    end
    exp_last = 0;

    // Simultaneous reads.
    step();
    m0_ren = 1'b1; m0_addr = 16'h0100;
    m1_ren = 1'b1; m1_addr = 16'h0200;
    @(negedge clk);
    check("contend_idle", '0);
    f = pick(exp_last);
    s = 1 - f;
    step();
    s_rd_valid = 1'b1; s_rdata = 32'h11111111;
    @(negedge clk);
    check("contend_first", rd_e(f, (f == 0) ? 16'h0100 : 16'h0200, 32'h11111111, 1'b1, 1'b0));
    exp_last = f;
    step();
    drop_ren(f);
    s_rd_valid = 1'b0;
    @(negedge clk);
    check("contend_gap", '0);
    step();
    s_rd_valid = 1'b1; s_rdata = 32'h22222222;
    @(negedge clk);
    check("contend_second", rd_e(s, (s == 0) ? 16'h0100 : 16'h0200, 32'h22222222, 1'b1, 1'b0));
    exp_last = s;
    step();
    drop_ren(s);
    s_rd_valid = 1'b0;
    @(negedge clk);
    check("contend_done", '0);

    // Unmapped read: forced completion on the 15th READ cycle.
    step();
    m0_ren = 1'b1; m0_addr = 16'h6000; s_rdata = 32'hFFFF0000;
    @(negedge clk);
    check("to_idle", '0);
    for (int k = 1; k <= 15; k++) begin
      step();
      @(negedge clk);
      if (k < 15) check($sformatf("to_wait%0d", k), rd_e(0, 16'h6000, 32'hFFFF0000, 1'b0, 1'b0));
      else        check("to_fire", rd_e(0, 16'h6000, 32'h0, 1'b1, 1'b1));
    end
    step();
    m0_ren = 1'b0;
    @(negedge clk);
    check("to_after", '0);

    // Same read, real data arrives on the timeout cycle.
    step();
    m0_ren = 1'b1;
    @(negedge clk);
    check("tv_idle", '0);
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 15) begin
        s_rd_valid = 1'b1; s_rdata = 32'h0BADF00D;
      end
      @(negedge clk);
      if (k < 15) check($sformatf("tv_wait%0d", k), rd_e(0, 16'h6000, 32'hFFFF0000, 1'b0, 1'b0));
      else        check("tv_win", rd_e(0, 16'h6000, 32'h0BADF00D, 1'b1, 1'b0));
    end
    step();
    m0_ren = 1'b0; s_rd_valid = 1'b0;
    @(negedge clk);
    check("tv_after", '0);
    exp_last = 0;

    // Reset during READ cycle 2, then a fresh read.
    step();
    m0_ren = 1'b1; m0_addr = 16'h0300; s_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_idle", '0);
    step();
    @(negedge clk);
    check("rst_rd1", rd_e(0, 16'h0300, 32'hCAFEF00D, 1'b0, 1'b0));
    step();
    rst_n = 1'b0;
    #1;
    check("rst_abort", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release", '0);
    step();
    s_rd_valid = 1'b1; s_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("rst_fresh", rd_e(0, 16'h0300, 32'h55AA55AA, 1'b1, 1'b0));
    step();
    m0_ren = 1'b0; s_rd_valid = 1'b0;
    @(negedge clk);
    check("rst_after", '0);
    exp_last = 0;

    // Continuous m0 writes against a held m1 read.
    step();
    m0_wen = 1'b1; m0_addr = 16'h0040; m0_wdata = 32'h5A5A0000; m0_wmask = 4'hF;
    m1_ren = 1'b1; m1_addr = 16'h0050;
    s_rd_valid = 1'b1; s_rdata = 32'h00000077;
    @(negedge clk);
    check("starve_idle", '0);
    for (int g = 0; g < 4; g++) begin
      w = pick(exp_last);
      step();
      @(negedge clk);
      if (w == 0) check($sformatf("starve_grant%0d", g), wr_e(0, 16'h0040, 32'h5A5A0000, 4'hF));
      else        check($sformatf("starve_grant%0d", g),
                        rd_e(1, 16'h0050, 32'h00000077, 1'b1, 1'b0));
      exp_last = w;
      step();
      @(negedge clk);
      check($sformatf("starve_gap%0d", g), '0);
    end
    m0_wen = 1'b0; m1_ren = 1'b0; s_rd_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
